// File: rtl/wb_openram_pkg.sv
// Shared definitions for Wishbone-fronted OpenRAM wrappers: FSM encoding and
// an elaboration-time clog2 helper.
package wb_openram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ACK   = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/wb_openram_decode.sv
// Combinational address decode for the banked OpenRAM region: region hit,
// bank index, word index and whether the bank actually exists.
module wb_openram_decode
  import wb_openram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          ADDR_WIDTH = 8,
  parameter int          NUM_BANKS  = 2,
  localparam int         BANK_BITS  = (clog2_f(NUM_BANKS) > 1) ? clog2_f(NUM_BANKS) : 1
) (
  input  logic [31:0]           adr_i,
  output logic                  hit_o,
  output logic                  in_range_o,
  output logic [BANK_BITS-1:0]  bank_o,
  output logic [ADDR_WIDTH-1:0] word_o
);

  localparam int TAG_LSB = ADDR_WIDTH + 2 + BANK_BITS;
  localparam logic [BANK_BITS:0] NB = NUM_BANKS[BANK_BITS:0];

  logic unused_byte_lane;

  // Byte lane bits carry no meaning on a word-addressed macro.
  assign unused_byte_lane = ^adr_i[1:0];

  assign hit_o      = (adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign word_o     = adr_i[ADDR_WIDTH+1:2];
  assign bank_o     = adr_i[ADDR_WIDTH+1+BANK_BITS:ADDR_WIDTH+2];
  assign in_range_o = ({1'b0, bank_o} < NB);

endmodule

// File: rtl/wb_openram_banked.sv
// Wishbone B4 classic slave mapping NUM_BANKS single-port OpenRAM macros onto
// one contiguous word region; one registered macro access per transfer.
module wb_openram_banked
  import wb_openram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          ADDR_WIDTH = 8,
  parameter int          NUM_BANKS  = 2,
  parameter int          READ_LAT   = 1
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [WB_SW-1:0]        wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [WB_DW-1:0]        wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic                    wbs_err_o,
  output logic [WB_DW-1:0]        wbs_dat_o,
  output logic                    clk0,
  output logic [NUM_BANKS-1:0]    csb0,
  output logic                    web0,
  output logic [WB_SW-1:0]        wmask0,
  output logic [ADDR_WIDTH-1:0]   addr0,
  output logic [WB_DW-1:0]        dout0,
  input  logic [WB_DW*NUM_BANKS-1:0] din0
);

  localparam int BANK_BITS = (clog2_f(NUM_BANKS) > 1) ? clog2_f(NUM_BANKS) : 1;

  logic                  dec_hit, dec_in_range;
  logic [BANK_BITS-1:0]  dec_bank;
  logic [ADDR_WIDTH-1:0] dec_word;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [BANK_BITS-1:0]  bank_q, bank_d;
  logic                  we_q, we_d;
  logic [NUM_BANKS-1:0]  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [WB_SW-1:0]      wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WB_DW-1:0]      dout_q, dout_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [WB_DW-1:0]      rdat_q, rdat_d;
  logic [WB_DW-1:0]      rd_slice;

  wb_openram_decode #(
    .BASE_ADDR (BASE_ADDR),
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_BANKS (NUM_BANKS)
  ) u_decode (
    .adr_i     (wbs_adr_i),
    .hit_o     (dec_hit),
    .in_range_o(dec_in_range),
    .bank_o    (dec_bank),
    .word_o    (dec_word)
  );

  assign clk0      = wb_clk_i;
  assign csb0      = csb_q;
  assign web0      = web_q;
  assign wmask0    = wmask_q;
  assign addr0     = addr_q;
  assign dout0     = dout_q;
  assign wbs_dat_o = rdat_q;
  // Gating with cyc keeps ack/err invisible once the master has abandoned the cycle.
  assign wbs_ack_o = ack_q & wbs_cyc_i;
  assign wbs_err_o = err_q & wbs_cyc_i;

  always_comb begin
    rd_slice = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_q == BANK_BITS'(b)) rd_slice = din0[WB_DW*b +: WB_DW];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    we_d    = we_q;
    csb_d   = '1;
    web_d   = 1'b1;
    wmask_d = '0;
    addr_d  = addr_q;
    dout_d  = dout_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdat_d  = rdat_q;
    case (state_q)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i && dec_hit) begin
          if (dec_in_range) begin
            state_d = ST_ISSUE;
            bank_d  = dec_bank;
            we_d    = wbs_we_i;
            web_d   = ~wbs_we_i;
            wmask_d = wbs_we_i ? wbs_sel_i : '0;
            addr_d  = dec_word;
            dout_d  = wbs_dat_i;
            for (int b = 0; b < NUM_BANKS; b++) begin
              if (dec_bank == BANK_BITS'(b)) csb_d[b] = 1'b0;
            end
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end
      // The macro samples at the end of ISSUE, so an aborted write still lands.
      ST_ISSUE: begin
        if (!wbs_cyc_i) begin
          state_d = ST_IDLE;
        end else if (we_q) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = 3'(READ_LAT);
        end
      end
      ST_WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 3'd1) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          rdat_d  = rd_slice;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bank_q  <= '0;
      we_q    <= 1'b0;
      csb_q   <= '1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      we_q    <= we_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

endmodule

// File: tb/tb_wb_openram_banked.sv
// Bench for wb_openram_banked: three banks, READ_LAT=2, behavioural macro model.
module tb_wb_openram_banked;

  localparam int          AW   = 8;
  localparam int          NB   = 3;
  localparam int          RL   = 2;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst_n;
  logic cyc, stb, we;
  logic [3:0] sel;
  logic [31:0] adr, wdat;
  logic ack, err;
  logic [31:0] rdat;
  logic clk0;
  logic [NB-1:0] csb0;
  logic web0;
  logic [3:0] wmask0;
  logic [AW-1:0] addr0;
  logic [31:0] dout0;
  logic [32*NB-1:0] din0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          resp;   // 0 none, 1 ack, 2 err
    int          lat;
    logic [31:0] rdat;
    logic [NB-1:0] csb;
    logic [3:0]  wmask;
  } vec_t;

  typedef struct {
    int          resp;
    int          lat;
    logic [31:0] rdat;
  } sb_t;

  vec_t vecs[16];
  sb_t  sb[$];
  logic [31:0] last_rd = 32'h0;

  always #5 clk = ~clk;

  wb_openram_banked #(
    .BASE_ADDR (BASE),
    .ADDR_WIDTH(AW),
    .NUM_BANKS (NB),
    .READ_LAT  (RL)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_err_o(err),
    .wbs_dat_o(rdat),
    .clk0     (clk0),
    .csb0     (csb0),
    .web0     (web0),
    .wmask0   (wmask0),
    .addr0    (addr0),
    .dout0    (dout0),
    .din0     (din0)
  );

  // Macro model: samples on clk0, read data valid only on the capture cycle.
  logic [31:0] mem [NB][2**AW];
  int          rd_cnt = 0;
  logic [1:0]  rd_bank = 2'd0;
  logic [31:0] rd_data = 32'h0;

  always @(posedge clk0) begin
    if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
    for (int b = 0; b < NB; b++) begin
      if (!csb0[b]) begin
        if (!web0) begin
          for (int i = 0; i < 4; i++)
            if (wmask0[i]) mem[b][addr0][8*i +: 8] <= dout0[8*i +: 8];
        end else begin
          rd_cnt  <= RL;
          rd_bank <= 2'(b);
          rd_data <= mem[b][addr0];
        end
      end
    end
  end

  always_comb begin
    din0 = {NB{32'hA5A5_A5A5}};
    if (rd_cnt == 1) din0[32*int'(rd_bank) +: 32] = rd_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input int drop_at,
                      output int resp, output int lat, output logic [31:0] rd,
                      output logic [NB-1:0] csb_s, output logic web_s,
                      output logic [3:0] wm_s, output logic [AW-1:0] ad_s,
                      output logic [31:0] do_s);
    bit done;
    done = 1'b0;
    resp = 0; lat = 0; rd = '0;
    csb_s = '1; web_s = 1'b1; wm_s = '0; ad_s = '0; do_s = '0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    for (int k = 1; k <= 12 && !done; k++) begin
      @(negedge clk);
      if (k == 1) begin
        csb_s = csb0; web_s = web0; wm_s = wmask0; ad_s = addr0; do_s = dout0;
      end
      chk("ack_err_exclusive", 32'(ack & err), 32'd0);
      if (ack || err) begin
        resp = ack ? 1 : 2;
        lat  = k;
        rd   = rdat;
        done = 1'b1;
      end else if (k == drop_at) begin
        done = 1'b1;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    sb_t e;
    int resp, lat;
    logic [31:0] rd, do_s;
    logic [NB-1:0] csb_s;
    logic web_s;
    logic [3:0] wm_s;
    logic [AW-1:0] ad_s;
    sb.push_back('{v.resp, v.lat, v.rdat});
    xfer(v.we, v.adr, v.sel, v.dat, 0, resp, lat, rd, csb_s, web_s, wm_s, ad_s, do_s);
    e = sb.pop_front();
    chk($sformatf("v%0d_resp", id), 32'(resp), 32'(e.resp));
    chk($sformatf("v%0d_latency", id), 32'(lat), 32'(e.lat));
    chk($sformatf("v%0d_csb0", id), 32'(csb_s), 32'(v.csb));
    if (e.resp == 1) begin
      chk($sformatf("v%0d_addr0", id), 32'(ad_s), 32'(v.adr[AW+1:2]));
      chk($sformatf("v%0d_wmask0", id), 32'(wm_s), 32'(v.wmask));
      chk($sformatf("v%0d_web0", id), 32'(web_s), 32'(!v.we));
      if (v.we) chk($sformatf("v%0d_dout0", id), do_s, v.dat);
      else begin
        chk($sformatf("v%0d_rdata", id), rd, e.rdat);
        last_rd = e.rdat;
      end
    end
    @(negedge clk);
    chk($sformatf("v%0d_dat_o_hold", id), rdat, last_rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int resp, lat;
    logic [31:0] rd, do_s;
    logic [NB-1:0] csb_s;
    logic web_s;
    logic [3:0] wm_s;
    logic [AW-1:0] ad_s;

    //            we    adr            sel      dat            resp lat  rdat           csb     wmask
    vecs[0]  = '{1'b1, 32'h3000_0404, 4'hF,    32'hDEAD_BEEF, 1, 2,    32'h0,         3'b101, 4'hF};
    vecs[1]  = '{1'b0, 32'h3000_0404, 4'hF,    32'h0,         1, 2+RL, 32'hDEAD_BEEF, 3'b101, 4'h0};
    vecs[2]  = '{1'b1, 32'h3000_0008, 4'hF,    32'h1111_1111, 1, 2,    32'h0,         3'b110, 4'hF};
    vecs[3]  = '{1'b1, 32'h3000_0008, 4'b0010, 32'h0000_AB00, 1, 2,    32'h0,         3'b110, 4'b0010};
    vecs[4]  = '{1'b0, 32'h3000_0008, 4'hF,    32'h0,         1, 2+RL, 32'h1111_AB11, 3'b110, 4'h0};
    vecs[5]  = '{1'b1, 32'h3000_0808, 4'hF,    32'h1234_5678, 1, 2,    32'h0,         3'b011, 4'hF};
    vecs[6]  = '{1'b0, 32'h3000_0808, 4'hF,    32'h0,         1, 2+RL, 32'h1234_5678, 3'b011, 4'h0};
    vecs[7]  = '{1'b1, 32'h3000_0C00, 4'hF,    32'h0BAD_0BAD, 2, 1,    32'h0,         3'b111, 4'h0};
    vecs[8]  = '{1'b0, 32'h3000_0C04, 4'hF,    32'h0,         2, 1,    32'h0,         3'b111, 4'h0};
    vecs[9]  = '{1'b1, 32'h3000_0008, 4'h0,    32'hFFFF_FFFF, 1, 2,    32'h0,         3'b110, 4'h0};
    vecs[10] = '{1'b0, 32'h3000_0008, 4'hF,    32'h0,         1, 2+RL, 32'h1111_AB11, 3'b110, 4'h0};
    vecs[11] = '{1'b1, 32'h3100_0000, 4'hF,    32'h5555_5555, 0, 0,    32'h0,         3'b111, 4'h0};
    vecs[12] = '{1'b0, 32'h3000_0404, 4'hF,    32'h0,         1, 2+RL, 32'hDEAD_BEEF, 3'b101, 4'h0};
    vecs[13] = '{1'b1, 32'h3000_0BFC, 4'hF,    32'h0000_0000, 1, 2,    32'h0,         3'b011, 4'hF};
    vecs[14] = '{1'b1, 32'h3000_0BFC, 4'b1000, 32'hAA00_0000, 1, 2,    32'h0,         3'b011, 4'b1000};
    vecs[15] = '{1'b0, 32'h3000_0BFC, 4'hF,    32'h0,         1, 2+RL, 32'hAA00_0000, 3'b011, 4'h0};

    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
    repeat (2) @(negedge clk);
    chk("reset_csb0", 32'(csb0), 32'(3'b111));
    chk("reset_web0", 32'(web0), 32'd1);
    chk("reset_wmask0", 32'(wmask0), 32'd0);
    chk("reset_addr0", 32'(addr0), 32'd0);
    chk("reset_dout0", dout0, 32'd0);
    chk("reset_ack_err", 32'({ack, err}), 32'd0);
    chk("reset_dat_o", rdat, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Abort a read in WAIT, then a write must start with normal latency.
    xfer(1'b0, 32'h3000_0808, 4'hF, 32'h0, 2, resp, lat, rd, csb_s, web_s, wm_s, ad_s, do_s);
    chk("abort_no_resp", 32'(resp), 32'd0);
    @(negedge clk);
    chk("abort_dat_o_hold", rdat, last_rd);
    xfer(1'b1, 32'h3000_0004, 4'hF, 32'hCAFE_F00D, 0, resp, lat, rd, csb_s, web_s, wm_s, ad_s, do_s);
    chk("post_abort_resp", 32'(resp), 32'd1);
    chk("post_abort_latency", 32'(lat), 32'd2);
    @(negedge clk);

    // Reset while the read is being issued to the macro.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0404; sel = 4'hF;
    @(negedge clk);
    chk("midrst_issue_csb0", 32'(csb0), 32'(3'b101));
    rst_n = 1'b0;
    #1;
    chk("midrst_csb0", 32'(csb0), 32'(3'b111));
    chk("midrst_web0", 32'(web0), 32'd1);
    chk("midrst_wmask0", 32'(wmask0), 32'd0);
    chk("midrst_addr0", 32'(addr0), 32'd0);
    chk("midrst_dout0", dout0, 32'd0);
    chk("midrst_ack_err", 32'({ack, err}), 32'd0);
    chk("midrst_dat_o", rdat, 32'd0);
    last_rd = 32'h0;
    stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("midrst_quiet_%0d", k), 32'({ack, err}), 32'd0);
    end
    cyc = 1'b0;
    @(negedge clk);

    run_vec(vecs[1], 100);
    run_vec(vecs[6], 101);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
